// File: rtl/fir_coeff_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fir_coeff_loader
//  Purpose  : Turns a valid/ready stream of 16-bit coefficient words into the
//             FIR coefficient-RAM update sequence. The sequence raises the
//             update flag, waits a setup time, and writes one word per
//             accepted beat at consecutive addresses. It then holds the flag
//             for a hold time and reports completion with a one-cycle pulse.
//  Ports    : iClk12M          12 MHz clock
//             iRsn             asynchronous active-low reset
//             iStart           one-cycle load request (honoured in IDLE only)
//             iCoeffValid      coefficient word valid
//             iCoeffData       coefficient word
//             oCoeffReady      word accepted this cycle when valid
//             oCoeffUpdateFlag filter coefficient-update flag
//             oCsnRam/oWrnRam  active-low RAM chip-select / write strobe
//             oAddrRam         RAM write address
//             oWtDtRam         RAM write data
//             oBusy            high in every state except IDLE
//             oDone            one-cycle completion pulse
//  Revision : 1.0  initial release
// ============================================================================
module fir_coeff_loader #(
  parameter int COEFF_NUM = 10,
  parameter int ADDR_W    = 6,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 3
) (
  input  logic              iClk12M,
  input  logic              iRsn,
  input  logic              iStart,
  input  logic              iCoeffValid,
  input  logic [15:0]       iCoeffData,
  output logic              oCoeffReady,
  output logic              oCoeffUpdateFlag,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [15:0]       oWtDtRam,
  output logic              oBusy,
  output logic              oDone
);

  // Word counter needs one extra bit so it can represent COEFF_NUM = 2^ADDR_W.
  localparam int CNT_W  = ADDR_W + 1;
  localparam int PH_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [CNT_W-1:0] c_COEFF_NUM  = CNT_W'(COEFF_NUM);
  localparam logic [CNT_W-1:0] c_LAST_WORD  = CNT_W'(COEFF_NUM - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);
  localparam logic [PH_W-1:0]  c_SETUP_LAST = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0]  c_HOLD_LAST  = PH_W'(HOLD_CYC - 1);
  localparam logic [PH_W-1:0]  c_PH_ONE     = PH_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_wordCnt;
  logic [PH_W-1:0]   r_phaseCnt;
  logic              r_flag;
  logic              r_csn;
  logic              r_wrn;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;
  logic              r_busy;
  logic              r_done;

  logic w_ready;
  logic w_accept;

  // Ready decodes state and counter only, so there is no path from the
  // valid input back to ready.
  assign w_ready  = (r_state == S_WRITE) && (r_wordCnt < c_COEFF_NUM);
  assign w_accept = w_ready && iCoeffValid;

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      r_state    <= S_IDLE;
      r_wordCnt  <= '0;
      r_phaseCnt <= '0;
      r_flag     <= 1'b0;
      r_csn      <= 1'b1;
      r_wrn      <= 1'b1;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_state    <= S_SETUP;
            r_wordCnt  <= '0;
            r_phaseCnt <= '0;
            r_flag     <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        S_SETUP: begin
          if (r_phaseCnt == c_SETUP_LAST) begin
            r_state    <= S_WRITE;
            r_phaseCnt <= '0;
          end else begin
            r_phaseCnt <= r_phaseCnt + c_PH_ONE;
          end
        end

        S_WRITE: begin
          // Strobes default inactive; an acceptance turns them on for
          // exactly the following cycle.
          r_csn <= 1'b1;
          r_wrn <= 1'b1;
          if (w_accept) begin
            r_csn     <= 1'b0;
            r_wrn     <= 1'b0;
            r_addr    <= r_wordCnt[ADDR_W-1:0];
            r_data    <= iCoeffData;
            r_wordCnt <= r_wordCnt + c_CNT_ONE;
            if (r_wordCnt == c_LAST_WORD) begin
              r_state    <= S_HOLD;
              r_phaseCnt <= '0;
            end
          end
        end

        S_HOLD: begin
          // The last word's strobe is visible during the first HOLD cycle.
          r_csn <= 1'b1;
          r_wrn <= 1'b1;
          if (r_phaseCnt == c_HOLD_LAST) begin
            r_state <= S_DONE;
            r_flag  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_phaseCnt <= r_phaseCnt + c_PH_ONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_addr  <= '0;
          r_data  <= '0;
        end

        default: begin
          r_state <= S_IDLE;
          r_flag  <= 1'b0;
          r_csn   <= 1'b1;
          r_wrn   <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign oCoeffReady      = w_ready;
  assign oCoeffUpdateFlag = r_flag;
  assign oCsnRam          = r_csn;
  assign oWrnRam          = r_wrn;
  assign oAddrRam         = r_addr;
  assign oWtDtRam         = r_data;
  assign oBusy            = r_busy;
  assign oDone            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fir_coeff_loader
//  Purpose  : Self-checking bench for fir_coeff_loader. It drives table-driven
//             load scenarios, a mid-load reset and randomized loads. The RAM
//             writes it observes are compared with the word list that was
//             offered to the loader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_coeff_loader;

  localparam int N  = 10;
  localparam int AW = 6;
  localparam int SU = 2;
  localparam int HO = 3;

  logic          clk = 1'b0;
  logic          rsn = 1'b0;
  logic          start = 1'b0;
  logic          vld = 1'b0;
  logic [15:0]   din = '0;
  logic          oCoeffReady;
  logic          oCoeffUpdateFlag;
  logic          oCsnRam;
  logic          oWrnRam;
  logic [AW-1:0] oAddrRam;
  logic [15:0]   oWtDtRam;
  logic          oBusy;
  logic          oDone;

  fir_coeff_loader #(
    .COEFF_NUM (N),
    .ADDR_W    (AW),
    .SETUP_CYC (SU),
    .HOLD_CYC  (HO)
  ) dut (
    .iClk12M          (clk),
    .iRsn             (rsn),
    .iStart           (start),
    .iCoeffValid      (vld),
    .iCoeffData       (din),
    .oCoeffReady      (oCoeffReady),
    .oCoeffUpdateFlag (oCoeffUpdateFlag),
    .oCsnRam          (oCsnRam),
    .oWrnRam          (oWrnRam),
    .oAddrRam         (oAddrRam),
    .oWtDtRam         (oWtDtRam),
    .oBusy            (oBusy),
    .oDone            (oDone)
  );

  always #42 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [15:0] loadWords[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chkIdleOutputs(input string tag);
    chk({tag, " flag"},  oCoeffUpdateFlag, 0);
    chk({tag, " csn"},   oCsnRam, 1);
    chk({tag, " wrn"},   oWrnRam, 1);
    chk({tag, " addr"},  oAddrRam, 0);
    chk({tag, " data"},  oWtDtRam, 0);
    chk({tag, " ready"}, oCoeffReady, 0);
    chk({tag, " busy"},  oBusy, 0);
    chk({tag, " done"},  oDone, 0);
  endtask

  // One complete load. Cycle n counts negedges after the start edge E, so the
  // value at n reflects edge E+n-1 and oDone is captured by the filter at E+n.
  task automatic runLoad(input string nm, input int gapAfter, input int gapLen,
                         input bit poke, input bit extra, input bit rnd,
                         input int expLat);
    logic [15:0]   src[$];
    logic [AW-1:0] sa[$];
    logic [15:0]   sd[$];
    int  accepted = 0;
    int  flagCyc  = 0;
    int  doneCnt  = 0;
    int  doneAt   = -1;
    int  firstStb = -1;
    int  lastStb  = -1;
    int  gapLeft  = 0;
    int  n        = 0;
    bit  acc;
    bit  pokedWrite = 1'b0;
    bit  readyChecked = 1'b0;

    src = loadWords;
    if (extra) src.push_back(16'hBEEF);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    vld = (src.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
    din = (src.size() > 0) ? src[0] : 16'h0;

    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({nm, " flag after start"}, oCoeffUpdateFlag, 1);
        chk({nm, " busy after start"}, oBusy, 1);
      end
      if (oCoeffUpdateFlag) flagCyc++;
      if (!oCsnRam) begin
        sa.push_back(oAddrRam);
        sd.push_back(oWtDtRam);
        if (firstStb < 0) firstStb = n;
        lastStb = n;
        if (oWrnRam !== 1'b0) chk({nm, " wrn with csn"}, oWrnRam, 0);
      end
      if (oDone) begin
        doneCnt++;
        if (doneAt < 0) begin
          doneAt = n;
          chk({nm, " busy during done"}, oBusy, 1);
          chk({nm, " flag during done"}, oCoeffUpdateFlag, 0);
        end
      end
      if (doneAt > 0 && n == doneAt + 1) begin
        chk({nm, " busy after done"}, oBusy, 0);
        chk({nm, " addr after done"}, oAddrRam, 0);
        chk({nm, " data after done"}, oWtDtRam, 0);
      end
      if (extra && accepted == N && !readyChecked) begin
        readyChecked = 1'b1;
        chk({nm, " valid held for extra word"}, vld, 1);
        chk({nm, " ready after last word"}, oCoeffReady, 0);
      end
      acc = vld && oCoeffReady;
      if (poke && doneAt == n) start = 1'b1;
      if (doneAt > 0 && n >= doneAt + 4) break;

      @(posedge clk); #1;
      start = 1'b0;
      if (acc) begin
        void'(src.pop_front());
        accepted++;
        if (accepted == gapAfter) gapLeft = gapLen;
      end else if (gapLeft > 0) begin
        gapLeft--;
      end
      if (poke && accepted == 5 && !pokedWrite) begin
        pokedWrite = 1'b1;
        start = 1'b1;
      end
      vld = (src.size() > 0) && (gapLeft == 0) && (!rnd || $urandom_range(0, 3) != 0);
      din = (src.size() > 0) ? src[0] : 16'h0;
    end
    vld = 1'b0;

    if (doneAt < 0) begin
      chk({nm, " done timeout"}, 0, 1);
    end else begin
      chk({nm, " done pulses"}, doneCnt, 1);
      chk({nm, " flag cycles"}, flagCyc, doneAt - 1);
      if (expLat > 0) chk({nm, " done latency"}, doneAt, expLat);
      else            chk({nm, " latency >= min"}, (doneAt >= SU + N + HO + 1), 1);
    end
    chk({nm, " strobe count"}, sa.size(), N);
    for (int i = 0; i < N && i < sa.size(); i++) begin
      chk($sformatf("%s addr[%0d]", nm, i), sa[i], i);
      chk($sformatf("%s data[%0d]", nm, i), sd[i], loadWords[i]);
    end
    if (!rnd) begin
      chk({nm, " first strobe cycle"}, firstStb, SU + 2);
      chk({nm, " strobe span"}, lastStb - firstStb, N - 1 + gapLen);
      chk({nm, " words left unconsumed"}, src.size(), extra ? 1 : 0);
    end
  endtask

  typedef struct {
    string name;
    int    gapAfter;
    int    gapLen;
    bit    poke;
    bit    extra;
    int    expLat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stb;
    int guard;
    int idx;
    bit acc;

    vecs[0] = '{"basic",     -1, 0, 1'b0, 1'b0, 16};
    vecs[1] = '{"gap",        4, 3, 1'b0, 1'b0, 19};
    vecs[2] = '{"restart",   -1, 0, 1'b1, 1'b0, 16};
    vecs[3] = '{"extraword", -1, 0, 1'b0, 1'b1, 16};

    for (int i = 0; i < N; i++) loadWords.push_back(16'h0A01 + 16'(i));

    // Reset for one cycle with valid asserted; loader must stay idle.
    vld = 1'b1;
    din = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    chkIdleOutputs("in reset");
    rsn = 1'b1;
    repeat (2) @(negedge clk);
    chkIdleOutputs("idle after reset");
    vld = 1'b0;

    foreach (vecs[v]) begin
      runLoad(vecs[v].name, vecs[v].gapAfter, vecs[v].gapLen,
              vecs[v].poke, vecs[v].extra, 1'b0, vecs[v].expLat);
      if (vecs[v].poke) chk("restart stayed idle", oBusy, 0);
    end

    // Reset in the middle of a load, after five strobes.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    idx = 0;
    vld = 1'b1;
    din = loadWords[0];
    stb = 0;
    guard = 0;
    while (stb < 5 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (!oCsnRam) stb++;
      acc = vld && oCoeffReady;
      if (stb == 5) break;
      @(posedge clk); #1;
      if (acc) idx++;
      din = loadWords[idx];
    end
    chk("midreset five strobes", stb, 5);
    chk("midreset busy before", oBusy, 1);
    #10 rsn = 1'b0;
    #1;
    chkIdleOutputs("midreset immediate");
    vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rsn = 1'b1;
    repeat (3) @(negedge clk);
    chkIdleOutputs("midreset waits idle");
    runLoad("after reset", -1, 0, 1'b0, 1'b0, 1'b0, 16);

    // Randomized loads with random valid gaps and random data words.
    for (int r = 0; r < 4; r++) begin
      loadWords.delete();
      for (int i = 0; i < N; i++) loadWords.push_back(16'($urandom));
      runLoad($sformatf("random%0d", r), -1, 0, 1'b0, 1'b0, 1'b1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient loader that sits directly upstream of the reconfigurable FIR filter's coefficient RAM port. It accepts a stream of 16-bit coefficient words over a valid/ready handshake and converts it into the filter's update protocol. The protocol is: raise the coefficient-update flag, issue one active-low chip-select/write strobe per word at consecutive addresses, then hold the flag before releasing it. It runs in the 12 MHz domain alongside the filter and makes filter reconfiguration a single start pulse plus a word stream.

## Interface

Parameters:

- COEFF_NUM, 10, number of words written per load (1..2^ADDR_W)
- ADDR_W, 6, RAM address width
- SETUP_CYC, 2, cycles the flag is high before the first write is permitted (>=1)
- HOLD_CYC, 3, cycles the flag stays high after the last write (>=1)

Ports:

- iClk12M  in  1  12 MHz system clock
- iRsn  in  1  reset, asynchronous, active-low
- iStart  in  1  one-cycle request to begin a load
- iCoeffValid  in  1  coefficient word valid
- iCoeffData  in  16  coefficient word
- oCoeffReady  out  1  loader accepts a word this cycle
- oCoeffUpdateFlag  out  1  to filter iCoeffUpdateFlag
- oCsnRam  out  1  to filter iCsnRam, active-low
- oWrnRam  out  1  to filter iWrnRam, active-low
- oAddrRam  out  ADDR_W  to filter iAddrRam
- oWtDtRam  out  16  to filter iWtDtRam
- oBusy  out  1  high in any state other than IDLE
- oDone  out  1  one-cycle pulse on load completion

## Operation

- States: IDLE, SETUP, WRITE, HOLD, DONE.
- IDLE:
  - oCoeffReady=0 and all words are ignored.
  - iStart=1 -> SETUP; clear the word counter and the phase counter.
- SETUP:
  - oCoeffUpdateFlag=1.
  - After SETUP_CYC cycles -> WRITE.
- WRITE:
  - oCoeffUpdateFlag=1.
  - oCoeffReady=1 while word counter < COEFF_NUM.
  - A word is accepted on an edge where iCoeffValid & oCoeffReady.
  - Each accepted word produces a one-cycle write on the next cycle: oCsnRam=0, oWrnRam=0, oAddrRam=counter value at acceptance, oWtDtRam=iCoeffData. The counter then increments.
  - Cycles with no acceptance produce oCsnRam=oWrnRam=1. oAddrRam and oWtDtRam hold their last values.
  - Gaps in iCoeffValid are allowed with no timeout.
  - Acceptance of word COEFF_NUM-1 -> HOLD. oCoeffReady drops in the same edge, so no extra word is taken.
- HOLD:
  - oCoeffUpdateFlag=1 and oCsnRam=oWrnRam=1.
  - The final write strobe occurs in the first HOLD cycle.
  - After HOLD_CYC cycles -> DONE.
- DONE:
  - oCoeffUpdateFlag=0 and oDone=1 for one cycle.
  - Then -> IDLE. oAddrRam returns to 0 and oWtDtRam to 0.
- iStart outside IDLE is ignored, including in DONE.
- The counter never wraps. Addresses run 0..COEFF_NUM-1 exactly once per load.
- All outputs are registered. No combinational path from inputs to outputs, except oCoeffReady, which decodes state and counter only and never iCoeffValid.

## Timing

- Reset values (asynchronous, immediate): state IDLE, oCoeffUpdateFlag=0, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWtDtRam=0, oCoeffReady=0, oBusy=0, oDone=0, counters 0.
- Reset asserted mid-load aborts the load. The strobes deassert at once, and the partially written RAM is not restored. After reset release the loader waits in IDLE for a new iStart.
- Edge E samples iStart=1. oCoeffUpdateFlag and oBusy rise after E. The first possible acceptance edge is E+SETUP_CYC+1, with the strobe in the following cycle.
- Minimum load length with back-to-back valid, iStart edge to oDone high: SETUP_CYC+COEFF_NUM+HOLD_CYC+1 cycles. With defaults this is 16.
- oCoeffUpdateFlag high time: SETUP_CYC+COEFF_NUM+HOLD_CYC cycles minimum.
- oBusy falls the cycle after oDone.

## Test plan

- Reset with iRsn=0 for 1 cycle, then idle -> all outputs at reset values, and oCoeffReady=0 even with iCoeffValid=1.
- iStart pulse, then words 0x0A01..0x0A0A valid back-to-back:
  - Ten consecutive strobe cycles, addr 0..9, each data matching its word.
  - Flag high 15 cycles; oDone 16 cycles after the start edge.
- Same load with iCoeffValid deasserted for 3 cycles after the 4th word -> no strobe in the gap; addr 4 written with 0x0A05 after the gap; total length +3 cycles.
- iStart pulsed again during WRITE and in DONE -> ignored; exactly 10 strobes; one oDone.
- iCoeffValid held high with an 11th word present after the 10th -> oCoeffReady=0 at the 11th edge; the 11th word is not consumed; no 11th strobe.
- iRsn asserted after 5 words are written -> flag=0, Csn=Wrn=1, oBusy=0 immediately. A subsequent full load completes normally from addr 0.
